// File: rtl/bpred_mem_bank_if.sv
// Port bundle for the branch-predictor storage bank:
// instruction memory plus HOB/LOB perceptron weight tables.
interface bpred_mem_bank_if #(
    parameter int INSN_AW = 8,
    parameter int INSN_DW = 32,
    parameter int TBL_AW  = 6,
    parameter int HOB_DW  = 36,
    parameter int LOB_DW  = 60
);
    logic               insn_wren;
    logic [INSN_AW-1:0] insn_wraddr;
    logic [INSN_DW-1:0] insn_data;
    logic [INSN_AW-1:0] insn_rdaddr;
    logic [INSN_DW-1:0] insn_q;

    logic               hob_wren;
    logic [TBL_AW-1:0]  hob_wraddr;
    logic [HOB_DW-1:0]  hob_data;
    logic [TBL_AW-1:0]  hob_rdaddr;
    logic [HOB_DW-1:0]  hob_q;

    logic               lob_wren;
    logic [TBL_AW-1:0]  lob_wraddr;
    logic [LOB_DW-1:0]  lob_data;
    logic [TBL_AW-1:0]  lob_rdaddr;
    logic [LOB_DW-1:0]  lob_q;

    logic               clear_done;

    modport master (
        output insn_wren, insn_wraddr, insn_data, insn_rdaddr,
        output hob_wren, hob_wraddr, hob_data, hob_rdaddr,
        output lob_wren, lob_wraddr, lob_data, lob_rdaddr,
        input  insn_q, hob_q, lob_q, clear_done
    );

    modport slave (
        input  insn_wren, insn_wraddr, insn_data, insn_rdaddr,
        input  hob_wren, hob_wraddr, hob_data, hob_rdaddr,
        input  lob_wren, lob_wraddr, lob_data, lob_rdaddr,
        output insn_q, hob_q, lob_q, clear_done
    );
endinterface

// File: rtl/bpred_mem_bank.sv
// Three simple-dual-port synchronous RAMs for the predictor front end.
// Reset sweeps the HOB/LOB tables to zero; instruction memory is kept.
module bpred_mem_bank #(
    parameter int INSN_AW = 8,
    parameter int INSN_DW = 32,
    parameter int TBL_AW  = 6,
    parameter int HOB_DW  = 36,
    parameter int LOB_DW  = 60
) (
    input logic             clk,
    input logic             reset,
    bpred_mem_bank_if.slave bus
);
    localparam int INSN_DEPTH = 1 << INSN_AW;
    localparam int TBL_DEPTH  = 1 << TBL_AW;

    logic [INSN_DW-1:0] insn_mem [INSN_DEPTH];
    logic [HOB_DW-1:0]  hob_mem  [TBL_DEPTH];
    logic [LOB_DW-1:0]  lob_mem  [TBL_DEPTH];

    logic [TBL_AW-1:0] idx;
    logic              reset_d;

    logic              hob_we;
    logic [TBL_AW-1:0] hob_wa;
    logic [HOB_DW-1:0] hob_wd;
    logic              lob_we;
    logic [TBL_AW-1:0] lob_wa;
    logic [LOB_DW-1:0] lob_wd;

    // The sweep owns the table write ports while reset is high.
    always_comb begin
        hob_we = reset | bus.hob_wren;
        hob_wa = reset ? idx : bus.hob_wraddr;
        hob_wd = reset ? '0 : bus.hob_data;
        lob_we = reset | bus.lob_wren;
        lob_wa = reset ? idx : bus.lob_wraddr;
        lob_wd = reset ? '0 : bus.lob_data;
    end

    always_ff @(posedge clk) begin
        if (bus.insn_wren) begin
            insn_mem[bus.insn_wraddr] <= bus.insn_data;
        end
    end

    always_ff @(posedge clk) begin
        if (hob_we) begin
            hob_mem[hob_wa] <= hob_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (lob_we) begin
            lob_mem[lob_wa] <= lob_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.insn_q <= '0;
            bus.hob_q  <= '0;
            bus.lob_q  <= '0;
        end else begin
            bus.insn_q <= insn_mem[bus.insn_rdaddr];
            bus.hob_q  <= hob_mem[bus.hob_rdaddr];
            bus.lob_q  <= lob_mem[bus.lob_rdaddr];
        end
    end

    always_ff @(posedge clk) begin
        reset_d <= reset;
        if (reset) begin
            idx <= idx + TBL_AW'(1);
            if (&idx) begin
                bus.clear_done <= 1'b1;
            end else if (!reset_d) begin
                bus.clear_done <= 1'b0;
            end
        end else begin
            idx <= '0;
        end
    end
endmodule

// File: tb/tb_bpred_mem_bank.sv
// Bench for bpred_mem_bank: directed table, corner sequences,
// and random traffic against an array-based reference model.
module tb_bpred_mem_bank;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bpred_mem_bank_if bus ();

    bpred_mem_bank dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] insn_m [256];
    logic [35:0] hob_m  [64];
    logic [59:0] lob_m  [64];
    logic [31:0] m_insn_q;
    logic [35:0] m_hob_q;
    logic [59:0] m_lob_q;
    bit          m_done  = 1'b0;
    int          run     = 0;
    bit          m_valid = 1'b0;

    typedef struct {
        bit          wr;
        logic [7:0]  wa;
        logic [31:0] wd;
        logic [7:0]  ra;
        bit          check;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [5];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.insn_wren = 1'b0;
        bus.hob_wren  = 1'b0;
        bus.lob_wren  = 1'b0;
    endtask

    // Reference: reads see pre-edge contents; a reset run of
    // length n has cleared entries 0..n-1 (mod 64).
    task automatic model_edge();
        if (reset) begin
            m_insn_q = '0;
            m_hob_q  = '0;
            m_lob_q  = '0;
            hob_m[run % 64] = '0;
            lob_m[run % 64] = '0;
            run++;
            m_done = (run >= 64);
        end else begin
            m_insn_q = insn_m[bus.insn_rdaddr];
            m_hob_q  = hob_m[bus.hob_rdaddr];
            m_lob_q  = lob_m[bus.lob_rdaddr];
            run = 0;
            if (bus.hob_wren) hob_m[bus.hob_wraddr] = bus.hob_data;
            if (bus.lob_wren) lob_m[bus.lob_wraddr] = bus.lob_data;
        end
        if (bus.insn_wren) insn_m[bus.insn_wraddr] = bus.insn_data;
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        if (m_valid) begin
            chk("model insn_q", 64'(bus.insn_q), 64'(m_insn_q));
            chk("model hob_q", 64'(bus.hob_q), 64'(m_hob_q));
            chk("model lob_q", 64'(bus.lob_q), 64'(m_lob_q));
            chk("model clear_done", 64'(bus.clear_done), 64'(m_done));
        end
    endtask

    task automatic rd_tbl(int a);
        bus.hob_rdaddr = 6'(a);
        bus.lob_rdaddr = 6'(a);
        cyc();
    endtask

    initial begin
        int rst_left;

        vt[0] = '{1'b1, 8'h05, 32'hDEADBEEF, 8'h00, 1'b0, 32'h0};
        vt[1] = '{1'b1, 8'hFF, 32'h12345678, 8'h05, 1'b1, 32'hDEADBEEF};
        vt[2] = '{1'b0, 8'h00, 32'h0,        8'hFF, 1'b1, 32'h12345678};
        vt[3] = '{1'b1, 8'hFF, 32'hCAFEF00D, 8'hFF, 1'b1, 32'h12345678};
        vt[4] = '{1'b0, 8'h00, 32'h0,        8'hFF, 1'b1, 32'hCAFEF00D};

        for (int i = 0; i < 256; i++) insn_m[i] = '0;
        for (int i = 0; i < 64; i++) begin
            hob_m[i] = '0;
            lob_m[i] = '0;
        end
        idle();
        bus.insn_rdaddr = '0;
        bus.hob_rdaddr  = '0;
        bus.lob_rdaddr  = '0;
        bus.insn_wraddr = '0;
        bus.hob_wraddr  = '0;
        bus.lob_wraddr  = '0;
        bus.insn_data   = '0;
        bus.hob_data    = '0;
        bus.lob_data    = '0;

        // Long power-on reset; preload instruction memory meanwhile.
        reset = 1'b1;
        for (int c = 0; c < 300; c++) begin
            bus.insn_wren   = (c < 256);
            bus.insn_wraddr = 8'(c);
            bus.insn_data   = $urandom();
            cyc();
        end
        chk("reset insn_q", 64'(bus.insn_q), 64'h0);
        chk("reset hob_q", 64'(bus.hob_q), 64'h0);
        chk("reset clear_done", 64'(bus.clear_done), 64'h1);
        idle();
        reset = 1'b0;
        m_valid = 1'b1;

        for (int i = 0; i < 5; i++) begin
            bus.insn_wren   = vt[i].wr;
            bus.insn_wraddr = vt[i].wa;
            bus.insn_data   = vt[i].wd;
            bus.insn_rdaddr = vt[i].ra;
            cyc();
            if (vt[i].check) begin
                chk("table insn_q", 64'(bus.insn_q), 64'(vt[i].exp));
            end
        end
        idle();

        // Same-address read-during-write on HOB.
        bus.hob_wren = 1'b1;
        bus.hob_wraddr = 6'd3;
        bus.hob_data = 36'h000000001;
        cyc();
        bus.hob_data = 36'hFFFFFFFFF;
        bus.hob_rdaddr = 6'd3;
        cyc();
        chk("rdw old hob", 64'(bus.hob_q), 64'h1);
        idle();
        cyc();
        chk("rdw new hob", 64'(bus.hob_q), 64'hFFFFFFFFF);

        // LOB write with HOB write disabled at the same address.
        bus.lob_wren = 1'b1;
        bus.lob_wraddr = 6'd10;
        bus.lob_data = 60'h0FEDCBA9876543;
        bus.hob_wraddr = 6'd10;
        bus.hob_data = 36'h123456789;
        cyc();
        idle();
        rd_tbl(10);
        chk("indep lob", 64'(bus.lob_q), 64'h0FEDCBA9876543);
        chk("indep hob", 64'(bus.hob_q), 64'h0);

        // Fill tables, then full sweep with blocked writes.
        for (int i = 0; i < 64; i++) begin
            bus.hob_wren = 1'b1;
            bus.lob_wren = 1'b1;
            bus.hob_wraddr = 6'(i);
            bus.lob_wraddr = 6'(i);
            bus.hob_data = 36'hF00000000 | 36'(i);
            bus.lob_data = 60'hABC000000000000 | 60'(i);
            cyc();
        end
        idle();
        reset = 1'b1;
        for (int c = 0; c < 64; c++) begin
            idle();
            if (c == 5) begin
                bus.hob_wren = 1'b1;
                bus.hob_wraddr = 6'd40;
                bus.hob_data = 36'h555555555;
                bus.insn_wren = 1'b1;
                bus.insn_wraddr = 8'd7;
                bus.insn_data = 32'h00000001;
            end
            cyc();
            if (c == 0) chk("done drop", 64'(bus.clear_done), 64'h0);
            if (c == 62) chk("done early", 64'(bus.clear_done), 64'h0);
            if (c == 63) chk("done rise", 64'(bus.clear_done), 64'h1);
        end
        idle();
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            rd_tbl(i);
            chk("sweep hob", 64'(bus.hob_q), 64'h0);
            chk("sweep lob", 64'(bus.lob_q), 64'h0);
        end
        chk("done hold", 64'(bus.clear_done), 64'h1);
        bus.insn_rdaddr = 8'd7;
        cyc();
        chk("insn in reset", 64'(bus.insn_q), 64'h1);
        bus.insn_rdaddr = 8'h05;
        cyc();
        chk("insn kept", 64'(bus.insn_q), 64'hDEADBEEF);

        // Partial reset of 10 cycles.
        for (int i = 0; i < 64; i++) begin
            bus.hob_wren = 1'b1;
            bus.hob_wraddr = 6'(i);
            bus.hob_data = 36'hAAAAAAAAA;
            cyc();
        end
        idle();
        reset = 1'b1;
        for (int c = 0; c < 10; c++) cyc();
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            rd_tbl(i);
            chk("partial hob", 64'(bus.hob_q),
                (i < 10) ? 64'h0 : 64'hAAAAAAAAA);
        end
        chk("partial done", 64'(bus.clear_done), 64'h0);
        bus.hob_wren = 1'b1;
        bus.hob_wraddr = 6'd0;
        bus.hob_data = 36'h5;
        cyc();
        idle();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        rd_tbl(0);
        chk("restart hob0", 64'(bus.hob_q), 64'h0);
        rd_tbl(10);
        chk("restart hob10", 64'(bus.hob_q), 64'hAAAAAAAAA);

        // Random traffic with random-length reset bursts.
        rst_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (rst_left == 0 && $urandom_range(0, 49) == 0) begin
                rst_left = $urandom_range(1, 90);
            end
            reset = (rst_left > 0);
            if (rst_left > 0) rst_left--;
            bus.insn_wren   = $urandom_range(0, 1) == 1;
            bus.insn_wraddr = 8'($urandom());
            bus.insn_data   = $urandom();
            bus.insn_rdaddr = 8'($urandom());
            bus.hob_wren    = $urandom_range(0, 1) == 1;
            bus.hob_wraddr  = 6'($urandom());
            bus.hob_data    = 36'({$urandom(), $urandom()});
            bus.hob_rdaddr  = 6'($urandom());
            bus.lob_wren    = $urandom_range(0, 1) == 1;
            bus.lob_wraddr  = 6'($urandom());
            bus.lob_data    = 60'({$urandom(), $urandom()});
            bus.lob_rdaddr  = 6'($urandom());
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
